fetch_unit: RTL and testbench

Instruction fetch stage and the producer side of the fetch→decode payload interface. Holds the program counter and issues word requests to instruction memory over a valid/ready request channel with an in-order response channel. It buffers returned instructions and presents them in the fetch→decode pipeline register with stall, flush and redirect semantics. Branch and jump redirects come from execute; an epoch bit discards responses that were in flight when the redirect happened.

---
 rtl/fetch_unit_pkg.sv | 31 +++
 rtl/fetch_unit_fifo.sv | 52 +++++
 rtl/fetch_unit.sv | 131 +++++++++++++
 tb/tb_fetch_unit.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared types for the fetch stage and the fetch->decode payload interface.
package pack;

  localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic stall;
    logic flush;
  } control;

  typedef struct packed {
    logic [31:0] instruction;
    logic [31:0] programCounter;
    logic [31:0] programCounterPlus4;
    logic        valid;
  } fetchDecodePayload_;

  // Tag kept for each request still waiting on memory.
  typedef struct packed {
    logic [31:0] programCounter;
    logic        epoch;
  } fetchTag_;

  // Returned instruction waiting to enter the payload register.
  typedef struct packed {
    logic [31:0] instruction;
    logic [31:0] programCounter;
    logic [31:0] programCounterPlus4;
  } fetchEntry_;

endpackage

// File: rtl/fetch_unit_fifo.sv
// Synchronous FIFO with clear and occupancy count. DEPTH must be a power of 2
// so the pointers wrap naturally.
module fetch_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] pushData,
  input  logic             pop,
  output logic [WIDTH-1:0] popData,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty
);

  localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

  logic [WIDTH-1:0] storage [DEPTH];
  logic [AW-1:0]    writePointer;
  logic [AW-1:0]    readPointer;
  logic             doPush;
  logic             doPop;

  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  assign doPush  = push && !full;
  assign doPop   = pop && !empty;
  assign popData = storage[readPointer];

  // Pointer and occupancy tracking; clear empties the queue without touching storage.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      writePointer <= '0;
      readPointer  <= '0;
      count        <= '0;
    end else begin
      if (doPush) writePointer <= writePointer + 1'b1;
      if (doPop)  readPointer  <= readPointer + 1'b1;
      count <= count + {{AW{1'b0}}, doPush} - {{AW{1'b0}}, doPop};
    end
  end

  // Entry storage; stale contents are harmless because count governs visibility.
  always_ff @(posedge clock) begin
    if (doPush) storage[writePointer] <= pushData;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, request issue under credit, epoch-filtered response
// capture and the fetch->decode payload register.
module fetch_unit
  import pack::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT,
  parameter int unsigned FETCH_DEPTH  = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  control             fetchDecodeControl,
  input  logic               redirectValid,
  input  logic [31:0]        redirectTarget,
  output logic               imemRequestValid,
  input  logic               imemRequestReady,
  output logic [31:0]        imemAddress,
  input  logic               imemResponseValid,
  input  logic [31:0]        imemResponseData,
  output fetchDecodePayload_ fetchDecodePayload
);

  localparam int unsigned CW          = $clog2(FETCH_DEPTH);
  localparam logic [CW+1:0] DEPTH_LIMIT = FETCH_DEPTH[CW+1:0];

  logic [31:0] fetchPC;
  logic        epoch;

  fetchTag_    inFlightPushData;
  fetchTag_    inFlightHead;
  logic [CW:0] inFlightCount;
  logic        inFlightFull;
  logic        inFlightEmpty;

  fetchEntry_  bufferPushData;
  fetchEntry_  bufferHead;
  logic [CW:0] bufferCount;
  logic        bufferFull;
  logic        bufferEmpty;

  logic [CW+1:0] outstanding;
  logic          requestAccepted;
  logic          responseAccepted;
  logic          keepResponse;
  logic          advance;
  logic          bufferPop;

  // Buffered entries count against credit so the response buffer can never overflow.
  assign outstanding      = {1'b0, inFlightCount} + {1'b0, bufferCount};
  assign imemRequestValid = !reset && !redirectValid && !inFlightFull &&
                            (outstanding < DEPTH_LIMIT);
  assign imemAddress      = fetchPC;
  assign requestAccepted  = imemRequestValid && imemRequestReady;

  // An empty in-flight FIFO means the response predates the last reset.
  assign responseAccepted = imemResponseValid && !inFlightEmpty;
  assign keepResponse     = responseAccepted && !redirectValid && !bufferFull &&
                            (inFlightHead.epoch == epoch);

  assign advance   = !redirectValid && !fetchDecodeControl.flush && !fetchDecodeControl.stall;
  assign bufferPop = advance && !bufferEmpty;

  assign inFlightPushData = '{programCounter: fetchPC, epoch: epoch};
  assign bufferPushData   = '{instruction:         imemResponseData,
                              programCounter:      inFlightHead.programCounter,
                              programCounterPlus4: inFlightHead.programCounter + 32'd4};

  fetch_fifo #(
    .WIDTH($bits(fetchTag_)),
    .DEPTH(FETCH_DEPTH)
  ) inFlightFifo (
    .clock   (clock),
    .reset   (reset),
    .clear   (1'b0),
    .push    (requestAccepted),
    .pushData(inFlightPushData),
    .pop     (responseAccepted),
    .popData (inFlightHead),
    .count   (inFlightCount),
    .full    (inFlightFull),
    .empty   (inFlightEmpty)
  );

  fetch_fifo #(
    .WIDTH($bits(fetchEntry_)),
    .DEPTH(FETCH_DEPTH)
  ) responseBuffer (
    .clock   (clock),
    .reset   (reset),
    .clear   (redirectValid),
    .push    (keepResponse),
    .pushData(bufferPushData),
    .pop     (bufferPop),
    .popData (bufferHead),
    .count   (bufferCount),
    .full    (bufferFull),
    .empty   (bufferEmpty)
  );

  // PC and epoch: redirect retargets and flips the epoch, otherwise step on accept.
  always_ff @(posedge clock) begin
    if (reset) begin
      fetchPC <= RESET_VECTOR;
      epoch   <= 1'b0;
    end else if (redirectValid) begin
      fetchPC <= {redirectTarget[31:2], 2'b00};
      epoch   <= ~epoch;
    end else if (requestAccepted) begin
      fetchPC <= fetchPC + 32'd4;
    end
  end

  // Payload register: reset > redirect/flush > stall > advance (head or bubble).
  always_ff @(posedge clock) begin
    if (reset) begin
      fetchDecodePayload <= '0;
    end else if (redirectValid || fetchDecodeControl.flush) begin
      fetchDecodePayload.valid       <= 1'b0;
      fetchDecodePayload.instruction <= '0;
    end else if (fetchDecodeControl.stall) begin
      fetchDecodePayload <= fetchDecodePayload;
    end else if (!bufferEmpty) begin
      fetchDecodePayload <= '{instruction:         bufferHead.instruction,
                              programCounter:      bufferHead.programCounter,
                              programCounterPlus4: bufferHead.programCounterPlus4,
                              valid:               1'b1};
    end else begin
      fetchDecodePayload <= '0;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming, backpressure, stall under credit,
// redirect with stale responses, flush, and a wrapping reset vector.
module tb_fetch_unit;
  import pack::*;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic               reset;
  control             ctl;
  logic               redirectValid;
  logic [31:0]        redirectTarget;
  logic               reqValid, reqReady;
  logic [31:0]        addr;
  logic               respValid;
  logic [31:0]        respData;
  fetchDecodePayload_ payload;

  logic               reqValid2;
  logic [31:0]        addr2;
  logic               respValid2;
  logic [31:0]        respData2;
  fetchDecodePayload_ payload2;

  int tests = 0;
  int failures = 0;
  int cycle = 0;
  int latency = 1;

  logic [31:0] pendAddr[$];
  int          pendDue[$];
  logic        acc2Prev;
  logic [31:0] addr2Prev;

  fetch_unit dut (
    .clock             (clock),
    .reset             (reset),
    .fetchDecodeControl(ctl),
    .redirectValid     (redirectValid),
    .redirectTarget    (redirectTarget),
    .imemRequestValid  (reqValid),
    .imemRequestReady  (reqReady),
    .imemAddress       (addr),
    .imemResponseValid (respValid),
    .imemResponseData  (respData),
    .fetchDecodePayload(payload)
  );

  fetch_unit #(
    .RESET_VECTOR(32'hFFFF_FFF8)
  ) dutWrap (
    .clock             (clock),
    .reset             (reset),
    .fetchDecodeControl(2'b00),
    .redirectValid     (1'b0),
    .redirectTarget    (32'h0),
    .imemRequestValid  (reqValid2),
    .imemRequestReady  (1'b1),
    .imemAddress       (addr2),
    .imemResponseValid (respValid2),
    .imemResponseData  (respData2),
    .fetchDecodePayload(payload2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp)
    else begin
      failures++;
      $error("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // One clock: drive memory responses, record accepted requests, step past the edge.
  task automatic tick();
    cycle++;
    if (pendAddr.size() > 0 && pendDue[0] <= cycle) begin
      respValid = 1'b1;
      respData  = pendAddr[0] ^ 32'hA5A5_0000;
      void'(pendAddr.pop_front());
      void'(pendDue.pop_front());
    end else begin
      respValid = 1'b0;
      respData  = '0;
    end
    respValid2 = acc2Prev;
    respData2  = addr2Prev ^ 32'hA5A5_0000;
    #1;
    if (reqValid && reqReady) begin
      pendAddr.push_back(addr);
      pendDue.push_back(cycle + latency);
    end
    acc2Prev  = reqValid2;
    addr2Prev = addr2;
    @(posedge clock);
    #1;
  endtask

  task automatic expectPayload(input string tag, input logic [31:0] pc);
    check({tag, "_valid"}, {31'b0, payload.valid}, 32'd1);
    check({tag, "_pc"}, payload.programCounter, pc);
    check({tag, "_pc4"}, payload.programCounterPlus4, pc + 32'd4);
    check({tag, "_instr"}, payload.instruction, pc ^ 32'hA5A5_0000);
  endtask

  task automatic expectBubble(input string tag);
    check({tag, "_valid"}, {31'b0, payload.valid}, 32'd0);
    check({tag, "_instr"}, payload.instruction, 32'd0);
  endtask

  initial begin
    reset = 1'b1; ctl = '0; redirectValid = 1'b0; redirectTarget = '0;
    reqReady = 1'b1; respValid = 1'b0; respData = '0;
    respValid2 = 1'b0; respData2 = '0; acc2Prev = 1'b0; addr2Prev = '0;
    tick(); tick();
    check("reset_req_valid", {31'b0, reqValid}, 32'd0);
    check("reset_payload_valid", {31'b0, payload.valid}, 32'd0);
    check("reset_payload_instr", payload.instruction, 32'd0);
    check("reset_payload_pc", payload.programCounter, 32'd0);
    check("reset_wrap_req_valid", {31'b0, reqValid2}, 32'd0);

    // 1: single-cycle memory streaming
    reset = 1'b0; #1;
    check("t1_addr0", addr, 32'h0);
    check("t1_req_valid", {31'b0, reqValid}, 32'd1);
    check("t6_addr0", addr2, 32'hFFFF_FFF8);
    tick();
    check("t1_addr1", addr, 32'h4);
    check("t6_addr1", addr2, 32'hFFFF_FFFC);
    tick();
    check("t1_addr2", addr, 32'h8);
    check("t6_addr2", addr2, 32'h0);
    expectBubble("t1_first_bubble");
    tick();
    expectPayload("t1_p0", 32'h0);
    check("t6_p0_pc", payload2.programCounter, 32'hFFFF_FFF8);
    tick();
    expectPayload("t1_p4", 32'h4);
    check("t6_p1_pc", payload2.programCounter, 32'hFFFF_FFFC);
    check("t6_p1_pc4_wrap", payload2.programCounterPlus4, 32'h0);
    tick();
    expectPayload("t1_p8", 32'h8);
    check("t6_p2_pc", payload2.programCounter, 32'h0);

    // 2: memory not ready for 5 cycles
    reqReady = 1'b0;
    tick(); expectPayload("t2_p12", 32'hC);
    tick(); expectPayload("t2_p16", 32'h10);
    tick(); expectBubble("t2_bubble_a");
    tick(); tick();
    expectBubble("t2_bubble_b");
    check("t2_addr_held", addr, 32'h14);
    reqReady = 1'b1;
    tick(); expectBubble("t2_bubble_c");
    tick(); expectBubble("t2_bubble_d");
    tick(); expectPayload("t2_p20", 32'h14);
    tick(); expectPayload("t2_p24", 32'h18);

    // 3: three-cycle memory with the payload stalled
    latency = 3; ctl.stall = 1'b1;
    tick(); tick();
    check("t3_credit_exhausted", {31'b0, reqValid}, 32'd0);
    tick(); tick(); tick(); tick();
    check("t3_still_no_req", {31'b0, reqValid}, 32'd0);
    check("t3_addr_held", addr, 32'h2C);
    expectPayload("t3_held", 32'h18);
    ctl.stall = 1'b0;
    tick(); expectPayload("t3_p28", 32'h1C);
    tick(); expectPayload("t3_p32", 32'h20);
    tick(); expectPayload("t3_p36", 32'h24);
    tick(); expectPayload("t3_p40", 32'h28);
    tick(); expectBubble("t3_bubble");
    tick(); expectPayload("t3_p44", 32'h2C);
    tick(); expectPayload("t3_p48", 32'h30);

    // 4: redirect with two requests in flight
    redirectValid = 1'b1; redirectTarget = 32'h0000_0103; #1;
    check("t4_no_req_on_redirect", {31'b0, reqValid}, 32'd0);
    tick();
    redirectValid = 1'b0; latency = 1; #1;
    check("t4_addr_redirect", addr, 32'h100);
    expectBubble("t4_redirect_bubble");
    tick(); expectBubble("t4_stale_a");
    tick(); expectBubble("t4_stale_b");
    tick(); expectBubble("t4_stale_c");
    tick(); expectPayload("t4_p100", 32'h100);

    // 5: flush without redirect
    ctl.flush = 1'b1;
    tick(); expectBubble("t5_flush");
    ctl.flush = 1'b0;
    tick(); expectPayload("t5_p104", 32'h104);
    tick(); expectPayload("t5_p108", 32'h108);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
